// File: rtl/base_pkg.sv
// Shared helpers for the base_rr_* steering blocks: credit-counter width and
// one-hot vector rotation over a runtime number of ways.
package base_pkg;

    localparam int unsigned MaxWays = 32;

    typedef logic [MaxWays-1:0] wvec_t;

    function automatic int unsigned cred_w(input int unsigned credits);
        return $clog2(credits + 1);
    endfunction

    // Moves bit i to bit (i + amt) mod n; bits at n and above are cleared.
    function automatic wvec_t onehot_rot(input wvec_t v, input int unsigned amt,
                                         input int unsigned n);
        wvec_t       r;
        int unsigned idx;
        r = '0;
        for (int unsigned i = 0; i < MaxWays; i++) begin
            if (i < n) begin
                idx = (i + amt) % n;
                r[idx[4:0]] = v[i[4:0]];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/base_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first requester at or
// after i_ptr, wrapping past ways-1 back to 0.
module base_rr_pick
    import base_pkg::*;
#(
    parameter int unsigned ways = 2,
    parameter int unsigned PtrW = $clog2(ways)
) (
    input  logic [0:ways-1] i_req,
    input  logic [PtrW-1:0] i_ptr,
    output logic [0:ways-1] o_gnt
);

    wvec_t       w_req;
    wvec_t       w_rot;
    wvec_t       w_first;
    wvec_t       w_back;
    int unsigned w_ptr;

    // Rotate so the pointer way sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        w_req = '0;
        for (int k = 0; k < ways; k++) w_req[k] = i_req[k];
        w_ptr   = 32'(i_ptr);
        w_rot   = onehot_rot(w_req, ways - w_ptr, ways);
        w_first = w_rot & (~w_rot + wvec_t'(1));
        w_back  = onehot_rot(w_first, w_ptr, ways);
        o_gnt   = '0;
        for (int k = 0; k < ways; k++) o_gnt[k] = w_back[k];
    end

endmodule

// File: rtl/base_rr_steer.sv
// Credit-based round-robin steering of one valid/ready stream onto `ways` consumers.
// Define BASE_RR_STEER_PKT_EN to keep all beats of a packet on one way (adds i_e).
module base_rr_steer
    import base_pkg::*;
#(
    parameter int unsigned ways    = 2,
    parameter int unsigned credits = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_v,
    output logic            i_r,
    output logic [0:ways-1] o_v,
    input  logic [0:ways-1] o_r,
    output logic [0:ways-1] sel,
    input  logic [0:ways-1] cr_v,
    output logic            o_idle,
    output logic            o_err
`ifdef BASE_RR_STEER_PKT_EN
    ,
    input  logic            i_e
`endif
);

    localparam int unsigned CredW = cred_w(credits);
    localparam int unsigned PtrW  = $clog2(ways);

    typedef logic [CredW-1:0] cred_t;

    localparam cred_t           CredFull = cred_t'(credits);
    localparam logic [PtrW-1:0] PtrLast  = PtrW'(ways - 1);

    cred_t           r_cred   [ways];
    cred_t           w_cred_d [ways];
    logic [PtrW-1:0] r_ptr;
    logic [PtrW-1:0] w_ptr_d;
    logic            r_err;
    logic            w_err_d;
    logic [0:ways-1] w_elig;
    logic [0:ways-1] w_gnt;
    logic [0:ways-1] w_xfer;
    logic [PtrW-1:0] w_xk;
    logic [PtrW-1:0] w_ptr_inc;
    logic            w_any;

    always_comb begin
        for (int k = 0; k < ways; k++) w_elig[k] = o_r[k] & (r_cred[k] != '0);
    end

    base_rr_pick #(
        .ways (ways),
        .PtrW (PtrW)
    ) u_pick (
        .i_req (w_elig),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    assign i_r    = |sel;
    assign o_v    = sel & {ways{i_v}};
    assign w_xfer = o_v & o_r;

    always_comb begin
        w_any = |w_xfer;
        w_xk  = '0;
        for (int k = 0; k < ways; k++) begin
            if (w_xfer[k]) w_xk = PtrW'(k);
        end
        w_ptr_inc = (w_xk == PtrLast) ? '0 : w_xk + 1'b1;
    end

`ifdef BASE_RR_STEER_PKT_EN
    logic            r_lock;
    logic            w_lock_d;
    logic [PtrW-1:0] r_lw;
    logic [PtrW-1:0] w_lw_d;

    // A locked packet may only continue on its own way, stalling if that way is not eligible.
    always_comb begin
        sel = w_gnt;
        if (r_lock) begin
            sel       = '0;
            sel[r_lw] = w_elig[r_lw];
        end
    end

    always_comb begin
        w_ptr_d  = r_ptr;
        w_lock_d = r_lock;
        w_lw_d   = r_lw;
        if (w_any) begin
            if (i_e) begin
                w_lock_d = 1'b0;
                w_ptr_d  = w_ptr_inc;
            end else begin
                w_lock_d = 1'b1;
                w_lw_d   = w_xk;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock <= 1'b0;
            r_lw   <= '0;
        end else begin
            r_lock <= w_lock_d;
            r_lw   <= w_lw_d;
        end
    end
`else
    assign sel     = w_gnt;
    assign w_ptr_d = w_any ? w_ptr_inc : r_ptr;
`endif

    always_comb begin
        w_err_d = r_err;
        for (int k = 0; k < ways; k++) begin
            w_cred_d[k] = r_cred[k];
            case ({w_xfer[k], cr_v[k]})
                2'b10: w_cred_d[k] = r_cred[k] - 1'b1;
                2'b01: begin
                    if (r_cred[k] == CredFull) w_err_d = 1'b1;
                    else                       w_cred_d[k] = r_cred[k] + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_idle = 1'b1;
        for (int k = 0; k < ways; k++) begin
            if (r_cred[k] != CredFull) o_idle = 1'b0;
        end
    end

    assign o_err = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ways; k++) r_cred[k] <= CredFull;
            r_ptr <= '0;
            r_err <= 1'b0;
        end else begin
            for (int k = 0; k < ways; k++) r_cred[k] <= w_cred_d[k];
            r_ptr <= w_ptr_d;
            r_err <= w_err_d;
        end
    end

endmodule

// File: tb/tb_base_rr_steer.sv
// Bench for base_rr_steer: directed literal checks plus random traffic compared on
// every cycle against a behavioural model of the credit/round-robin rules.
module tb_base_rr_steer;

    localparam int W = 4;
    localparam int C = 2;
`ifdef BASE_RR_STEER_PKT_EN
    localparam bit Pkt = 1'b1;
`else
    localparam bit Pkt = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_v;
    logic         i_r;
    logic [0:W-1] o_v;
    logic [0:W-1] o_r;
    logic [0:W-1] sel;
    logic [0:W-1] cr_v;
    logic         o_idle;
    logic         o_err;
    logic         i_e;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: per-way credits, pointer, sticky error, packet lock.
    int m_cred [W];
    int m_ptr;
    bit m_err;
    bit m_lock;
    int m_lw;

    logic [0:W-1] exp_rot [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};

    base_rr_steer #(
        .ways    (W),
        .credits (C)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_v    (i_v),
        .i_r    (i_r),
        .o_v    (o_v),
        .o_r    (o_r),
        .sel    (sel),
        .cr_v   (cr_v),
        .o_idle (o_idle),
        .o_err  (o_err)
`ifdef BASE_RR_STEER_PKT_EN
        ,
        .i_e    (i_e)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int w = 0; w < W; w++) m_cred[w] = C;
        m_ptr  = 0;
        m_err  = 1'b0;
        m_lock = 1'b0;
        m_lw   = 0;
    endtask

    // Way that would receive a beat now, or -1.
    function automatic int m_pick();
        if (m_lock) return (o_r[m_lw] && m_cred[m_lw] > 0) ? m_lw : -1;
        for (int d = 0; d < W; d++) begin
            if (o_r[(m_ptr + d) % W] && m_cred[(m_ptr + d) % W] > 0) return (m_ptr + d) % W;
        end
        return -1;
    endfunction

    task automatic model_check();
        int           k;
        bit           full;
        logic [0:W-1] es;
        k  = m_pick();
        es = '0;
        if (k >= 0) es[k] = 1'b1;
        full = 1'b1;
        for (int w = 0; w < W; w++) if (m_cred[w] != C) full = 1'b0;
        chk("m_sel", sel, es);
        chk("m_i_r", i_r, k >= 0);
        chk("m_o_v", o_v, i_v ? es : '0);
        chk("m_idle", o_idle, full);
        chk("m_err", o_err, m_err);
    endtask

    // Advance the model to the state after the coming rising edge.
    task automatic model_step();
        int k;
        bit x;
        k = m_pick();
        x = (k >= 0) && i_v;
        for (int w = 0; w < W; w++) begin
            if (x && k == w && cr_v[w]) begin
            end else if (x && k == w) begin
                m_cred[w]--;
            end else if (cr_v[w]) begin
                if (m_cred[w] == C) m_err = 1'b1;
                else                m_cred[w]++;
            end
        end
        if (x) begin
            if (Pkt && !i_e) begin
                m_lock = 1'b1;
                m_lw   = k;
            end else begin
                m_lock = 1'b0;
                m_ptr  = (k + 1) % W;
            end
        end
    endtask

    always @(negedge rst_n) model_reset();

    always @(negedge clk) begin
        if (!rst_n) model_reset();
        model_check();
        if (rst_n) model_step();
    end

    initial begin
        rst_n = 1'b0;
        i_v   = 1'b0;
        o_r   = 4'b1111;
        cr_v  = '0;
        i_e   = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_sel", sel, 4'b1000);
        chk("rst_i_r", i_r, 1'b1);
        chk("rst_o_v", o_v, 4'b0000);
        chk("rst_idle", o_idle, 1'b1);
        chk("rst_err", o_err, 1'b0);
        nxt();
        rst_n = 1'b1;

        // Rotation with every beat's credit echoed straight back.
        i_v = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cr_v = exp_rot[i];
            #1;
            chk("rot_sel", sel, exp_rot[i]);
            chk("rot_o_v", o_v, exp_rot[i]);
            nxt();
        end
        i_v  = 1'b0;
        cr_v = '0;
        #1;
        chk("rot_idle", o_idle, 1'b1);

        // Skip non-ready ways, starting from pointer 0.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        o_r   = 4'b0101;
        i_v   = 1'b1;
        #1;
        chk("skip_a", sel, 4'b0100);
        nxt();
        chk("skip_b", sel, 4'b0001);
        nxt();
        i_v = 1'b0;
        #1;
        chk("skip_idle", o_idle, 1'b0);

        // Exhaust way 1, then return a credit.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        o_r   = 4'b0100;
        i_v   = 1'b1;
        #1;
        chk("exh_1", i_r, 1'b1);
        nxt();
        chk("exh_2", i_r, 1'b1);
        nxt();
        chk("exh_empty", i_r, 1'b0);
        chk("exh_sel", sel, 4'b0000);
        cr_v = 4'b0100;
        #1;
        chk("exh_ret_same", i_r, 1'b0);
        nxt();
        chk("exh_ret_next", i_r, 1'b1);
        #1;
        nxt();
        cr_v = '0;
        i_v  = 1'b0;
        #1;
        chk("same_cycle", i_r, 1'b1);
        chk("same_err", o_err, 1'b0);

        // Overfill way 1 to raise the sticky error.
        cr_v = 4'b0100;
        nxt();
        cr_v = '0;
        #1;
        chk("full_idle", o_idle, 1'b1);
        chk("full_err", o_err, 1'b0);
        cr_v = 4'b0100;
        nxt();
        cr_v = '0;
        #1;
        chk("err_set", o_err, 1'b1);
        repeat (3) nxt();
        chk("err_sticky", o_err, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("err_clr", o_err, 1'b0);
        nxt();
        rst_n = 1'b1;
        o_r   = 4'b1111;

`ifdef BASE_RR_STEER_PKT_EN
        begin
            logic [0:W-1] p_or  [7] = '{4'b1111, 4'b1111, 4'b1111, 4'b1101, 4'b1111,
                                        4'b1111, 4'b1111};
            bit           p_e   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
            logic [0:W-1] p_sel [7] = '{4'b1000, 4'b0100, 4'b0010, 4'b0000, 4'b0010,
                                        4'b0010, 4'b0001};
            i_v = 1'b1;
            for (int i = 0; i < 7; i++) begin
                o_r  = p_or[i];
                i_e  = p_e[i];
                cr_v = p_sel[i];
                #1;
                chk("pkt_sel", sel, p_sel[i]);
                chk("pkt_o_v", o_v, p_sel[i]);
                nxt();
            end
            i_v  = 1'b0;
            i_e  = 1'b1;
            cr_v = '0;
            o_r  = 4'b1111;
        end
`endif

        // Random traffic, model-checked each cycle.
        for (int c = 0; c < 3000; c++) begin
            nxt();
            rst_n = ($urandom_range(0, 299) != 0);
            i_v   = ($urandom_range(0, 3) != 0);
            i_e   = Pkt ? ($urandom_range(0, 2) == 0) : 1'b1;
            for (int w = 0; w < W; w++) begin
                o_r[w]  = ($urandom_range(0, 3) != 0);
                cr_v[w] = ((m_cred[w] < C) || ($urandom_range(0, 199) == 0)) &&
                          ($urandom_range(0, 2) == 0);
            end
        end
        nxt();
        rst_n = 1'b1;
        i_v   = 1'b0;
        cr_v  = '0;
        repeat (2) nxt();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
